// File: rtl/buzzer_tone_gen.sv
// rtl/buzzer_tone_gen.sv - note code to buzzer square wave, with tone change, mute and illegal-code detection
module buzzer_tone_gen #(
    parameter int CLK_HZ = 100_000_000,
    parameter int HALF_W = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] note_in,
    input  logic       mute,
    output logic       buzzer,
    output logic       note_active,
    output logic       note_err
);

    localparam logic [HALF_W-1:0] HALF_DO = HALF_W'(CLK_HZ / (2 * 262));
    localparam logic [HALF_W-1:0] HALF_RE = HALF_W'(CLK_HZ / (2 * 294));
    localparam logic [HALF_W-1:0] HALF_MI = HALF_W'(CLK_HZ / (2 * 330));
    localparam logic [HALF_W-1:0] HALF_FA = HALF_W'(CLK_HZ / (2 * 349));
    localparam logic [HALF_W-1:0] HALF_SO = HALF_W'(CLK_HZ / (2 * 392));
    localparam logic [HALF_W-1:0] HALF_LA = HALF_W'(CLK_HZ / (2 * 440));
    localparam logic [HALF_W-1:0] HALF_SI = HALF_W'(CLK_HZ / (2 * 494));

    typedef enum logic {
        IDLE,
        TONE
    } state_t;

    logic              dec_legal;
    logic              dec_silent;
    logic [2:0]        dec_idx;
    logic [1:0]        dec_oct;

    logic              legal_q;
    logic [2:0]        idx_q;
    logic [1:0]        oct_q;
    logic [2:0]        idx_prev;
    logic [1:0]        oct_prev;

    logic [HALF_W-1:0] half_mid;
    logic [HALF_W-1:0] half;
    logic              tone_change;
    logic              last_count;

    state_t            state;
    logic [HALF_W-1:0] counter;

    // An absent octave bit decodes to mid, so it compares equal to an explicit mid bit.
    always_comb begin
        dec_silent = (note_in[6:0] == 7'd0);
        dec_legal  = $onehot(note_in[6:0]) && $onehot0(note_in[9:7]);
        dec_idx    = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (note_in[i]) begin
                dec_idx = 3'(i);
            end
        end
        if (note_in[7]) begin
            dec_oct = 2'd0;
        end else if (note_in[9]) begin
            dec_oct = 2'd2;
        end else begin
            dec_oct = 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            legal_q  <= 1'b0;
            note_err <= 1'b0;
            idx_q    <= 3'd0;
            oct_q    <= 2'd0;
            idx_prev <= 3'd0;
            oct_prev <= 2'd0;
        end else begin
            legal_q  <= dec_legal;
            note_err <= !dec_silent && !dec_legal;
            idx_q    <= dec_idx;
            oct_q    <= dec_oct;
            idx_prev <= idx_q;
            oct_prev <= oct_q;
        end
    end

    always_comb begin
        case (idx_q)
            3'd0:    half_mid = HALF_DO;
            3'd1:    half_mid = HALF_RE;
            3'd2:    half_mid = HALF_MI;
            3'd3:    half_mid = HALF_FA;
            3'd4:    half_mid = HALF_SO;
            3'd5:    half_mid = HALF_LA;
            default: half_mid = HALF_SI;
        endcase
        case (oct_q)
            2'd0:    half = half_mid << 1;
            2'd2:    half = half_mid >> 1;
            default: half = half_mid;
        endcase
        tone_change = (idx_q != idx_prev) || (oct_q != oct_prev);
        // >= keeps the counter bounded even if half shrinks under it
        last_count  = (counter >= (half - HALF_W'(1)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            counter     <= '0;
            buzzer      <= 1'b0;
            note_active <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    counter <= '0;
                    buzzer  <= 1'b0;
                    if (legal_q && !mute) begin
                        state       <= TONE;
                        note_active <= 1'b1;
                    end else begin
                        note_active <= 1'b0;
                    end
                end
                default: begin
                    if (mute || !legal_q) begin
                        state       <= IDLE;
                        counter     <= '0;
                        buzzer      <= 1'b0;
                        note_active <= 1'b0;
                    end else if (tone_change) begin
                        counter <= '0;
                        buzzer  <= 1'b0;
                    end else if (last_count) begin
                        counter <= '0;
                        buzzer  <= ~buzzer;
                    end else begin
                        counter <= counter + HALF_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// tb/tb_buzzer_tone_gen.sv - scoreboard bench for buzzer_tone_gen against a per-edge arithmetic tone model
module tb_buzzer_tone_gen;

    localparam int CLK_HZ = 1_048_000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] note_in = '0;
    logic       mute = 1'b0;
    logic       buzzer;
    logic       note_active;
    logic       note_err;

    buzzer_tone_gen #(
        .CLK_HZ(CLK_HZ),
        .HALF_W(20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .note_in    (note_in),
        .mute       (mute),
        .buzzer     (buzzer),
        .note_active(note_active),
        .note_err   (note_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   edge_no;
        logic buz;
        logic act;
        logic err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    // Model history: code driven one and two cycles back, whether the tone was on, and when it last (re)started.
    logic [9:0] m1 = '0;
    logic [9:0] m2 = '0;
    bit         act_prev = 1'b0;
    int         start_edge = 0;

    int freq[7] = '{262, 294, 330, 349, 392, 440, 494};

    function automatic bit legal_code(input logic [9:0] n);
        return ($countones(n[6:0]) == 1) && ($countones(n[9:7]) <= 1);
    endfunction

    function automatic bit illegal_code(input logic [9:0] n);
        return (n[6:0] != 7'd0) && !legal_code(n);
    endfunction

    function automatic int note_idx(input logic [9:0] n);
        for (int i = 0; i < 7; i++) if (n[i]) return i;
        return 0;
    endfunction

    function automatic int note_oct(input logic [9:0] n);
        if (n[7]) return 0;
        if (n[9]) return 2;
        return 1;
    endfunction

    function automatic int half_of(input logic [9:0] n);
        int b;
        b = CLK_HZ / (2 * freq[note_idx(n)]);
        case (note_oct(n))
            0:       return b * 2;
            2:       return b / 2;
            default: return b;
        endcase
    endfunction

    // Drive one cycle of stimulus just after an edge and queue what the next edge must produce.
    task automatic apply(input logic [9:0] n, input logic m);
        exp_t e;
        bit   act;
        note_in = n;
        mute    = m;
        act = legal_code(m1) && !m;
        if (act && (!act_prev || note_idx(m1) != note_idx(m2) || note_oct(m1) != note_oct(m2)))
            start_edge = cyc + 1;
        e.edge_no = cyc + 1;
        e.act     = act;
        e.err     = illegal_code(n);
        e.buz     = act ? ((((cyc + 1 - start_edge) / half_of(m1)) % 2) == 1) : 1'b0;
        exp_q.push_back(e);
        m2       = m1;
        m1       = n;
        act_prev = act;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic model_reset();
        m1       = '0;
        m2       = '0;
        act_prev = 1'b0;
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].edge_no <= cyc) begin
            mon_e = exp_q.pop_front();
            n_vec++;
            if (mon_e.edge_no != cyc || buzzer !== mon_e.buz || note_active !== mon_e.act
                || note_err !== mon_e.err) begin
                n_err++;
                $display("FAIL edge %0d (exp edge %0d): buzzer/active/err got %b%b%b expected %b%b%b",
                         cyc, mon_e.edge_no, buzzer, note_active, note_err,
                         mon_e.buz, mon_e.act, mon_e.err);
            end
        end
    end

    initial begin
        int         first;
        int         r;
        int         len;
        int         a;
        int         b;
        int         o;
        logic [9:0] n;
        logic       m;

        // Reset and silence
        repeat (5) @(posedge clk);
        #1;
        check("reset_buzzer", int'(buzzer), 0);
        check("reset_note_active", int'(note_active), 0);
        check("reset_note_err", int'(note_err), 0);
        rst = 1'b1;
        repeat (10000) apply(10'b000_0000000, 1'b0);

        // Mid Do from silence: first rise two cycles plus one half-period after apply
        first = -1;
        for (int i = 1; i <= 6100; i++) begin
            apply(10'b010_0000001, 1'b0);
            if (first < 0 && buzzer) first = i;
        end
        check("first_rise_mid_do", first, 2002);

        // Octave changes restart the period
        repeat (9000) apply(10'b001_0000001, 1'b0);
        repeat (2600) apply(10'b100_0000001, 1'b0);

        // Mid La, then the same La with no octave bit: no restart
        repeat (3000) apply(10'b010_0100000, 1'b0);
        repeat (3000) apply(10'b000_0100000, 1'b0);

        // Illegal codes
        repeat (20) apply(10'b010_0000011, 1'b0);
        check("err_two_notes", int'(note_err), 1);
        repeat (20) apply(10'b110_0000001, 1'b0);
        check("err_two_octaves", int'(note_err), 1);

        // Mute, unmute, then async reset during a high phase
        repeat (3000) apply(10'b010_0000001, 1'b0);
        repeat (500) apply(10'b010_0000001, 1'b1);
        first = -1;
        for (int i = 1; i <= 2100 && first < 0; i++) begin
            apply(10'b010_0000001, 1'b0);
            if (buzzer) first = i;
        end
        check("rise_after_unmute", first, 2001);
        repeat (1000) apply(10'b010_0000001, 1'b0);
        check("high_before_reset", int'(buzzer), 1);
        #1;
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset_buzzer", int'(buzzer), 0);
        check("async_reset_active", int'(note_active), 0);
        check("async_reset_err", int'(note_err), 0);
        note_in = '0;
        mute    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2100) apply(10'b010_0000001, 1'b0);

        // Every note in mid and high octave, held just past one half-period
        for (int i = 0; i < 7; i++) begin
            n = 10'b010_0000000 | (10'b1 << i);
            repeat (half_of(n) + 12) apply(n, 1'b0);
            n = 10'b100_0000000 | (10'b1 << i);
            repeat (half_of(n) + 12) apply(n, 1'b0);
        end

        // Random segments: legal/illegal/silent codes, random lengths, occasional mute
        for (int s = 0; s < 6; s++) begin
            r   = int'($urandom_range(0, 9));
            len = int'($urandom_range(1, 1200));
            m   = ($urandom_range(0, 4) == 0);
            if (r == 0) begin
                n = 10'b000_0000000;
            end else if (r == 1) begin
                a = int'($urandom_range(0, 6));
                b = (a + 1 + int'($urandom_range(0, 5))) % 7;
                n = 10'b010_0000000 | (10'b1 << a) | (10'b1 << b);
            end else begin
                a = int'($urandom_range(0, 6));
                o = int'($urandom_range(0, 3));
                n = 10'b1 << a;
                if (o < 3) n = n | (10'b1 << (7 + o));
            end
            repeat (len) apply(n, m);
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
